// File: rtl/nexys4_display_pkg.sv
// Shared constants and types for the Nexys4 SPI-controlled 7-segment display driver.
package nexys4_display_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [3:0] CMD_WRITE = 4'h1;
  localparam logic [3:0] CMD_READ  = 4'h0;

  localparam int REG_DP   = 0;
  localparam int REG_D10  = 1;
  localparam int REG_D32  = 2;
  localparam int REG_D54  = 3;
  localparam int REG_D76  = 4;
  localparam int REG_EN   = 5;
  localparam int NUM_REGS = 6;

  localparam logic [7:0] DP_RST    = 8'h00;
  localparam logic [7:0] DIGIT_RST = 8'h00;
  localparam logic [7:0] EN_RST    = 8'hFF;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

endpackage

// File: rtl/nexys4_spi_slave.sv
// SPI mode-3 style slave sampled by the system clock: synchronisers, 16-bit receive
// shifter with saturating bit counter, MISO shifter and a one-cycle frame_valid pulse.
module nexys4_spi_slave
  import nexys4_display_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [FRAME_BITS-1:0] tx_word,
  output logic                  frame_valid,
  output frame_t                frame_word
);

  logic [1:0] sclk_sync;
  logic [1:0] ss_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;
  logic       ss_prev;

  logic [FRAME_BITS-1:0] rx_sr;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [4:0]            bit_cnt;
  logic                  active;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync[1];
  assign ss_s      = ss_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_rise   = ss_s & ~ss_prev;
  assign ss_fall   = ~ss_s & ss_prev;

  // All SPI lines idle high, so the synchronisers reset high to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b11;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sclk_prev <= 1'b1;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      ss_sync   <= {ss_sync[0], spi_ss};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      frame_valid <= 1'b0;
      frame_word  <= '0;
    end else begin
      frame_valid <= ss_rise && (bit_cnt == 5'(FRAME_BITS));
      if (ss_rise) begin
        frame_word <= frame_t'(rx_sr);
      end
      if (ss_fall) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (sclk_rise && !ss_s) begin
        rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt != 5'(FRAME_BITS + 1)) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

  // The first sclk fall precedes any sampling edge, so bit 15 is held until a bit has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      tx_sr  <= '1;
    end else begin
      if (ss_fall) begin
        active <= 1'b1;
        tx_sr  <= tx_word;
      end else if (ss_rise) begin
        active <= 1'b0;
      end else if (sclk_fall && !ss_s && (bit_cnt != 5'd0)) begin
        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b1};
      end
    end
  end

  assign spi_miso = active ? tx_sr[FRAME_BITS-1] : 1'b1;

endmodule

// File: rtl/nexys4_display.sv
// Nexys4 8-digit 7-segment driver: SPI-written register file, digit scan and hex font.
module nexys4_display
  import nexys4_display_pkg::*;
#(
  parameter int REFRESH_DIV = 5000
) (
  input  logic       clk_5m_i,
  input  logic       rst_low_i,
  input  logic       spi_sclk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] segment_o,
  output logic [7:0] digit_o
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [NUM_REGS-1:0][7:0] regs;
  logic [3:0]               rd_addr;
  logic [7:0]               rd_data;
  logic                     frame_valid;
  frame_t                   rx_frame;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [2:0]       pair_sel;
  logic [7:0]       digit_pair;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  nexys4_spi_slave u_spi (
    .clk         (clk_5m_i),
    .rst_n       (rst_low_i),
    .spi_sclk    (spi_sclk_i),
    .spi_ss      (spi_ss_i),
    .spi_mosi    (spi_mosi_i),
    .spi_miso    (spi_miso_o),
    .tx_word     ({4'h0, rd_addr, rd_data}),
    .frame_valid (frame_valid),
    .frame_word  (rx_frame)
  );

  assign rd_data = (rd_addr < 4'(NUM_REGS)) ? regs[rd_addr[2:0]] : 8'h00;

  always_ff @(posedge clk_5m_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      regs    <= {EN_RST, {4{DIGIT_RST}}, DP_RST};
      rd_addr <= 4'h0;
    end else if (frame_valid) begin
      if (rx_frame.cmd == CMD_WRITE && rx_frame.addr < 4'(NUM_REGS)) begin
        regs[rx_frame.addr[2:0]] <= rx_frame.data;
      end else if (rx_frame.cmd == CMD_READ) begin
        rd_addr <= rx_frame.addr;
      end
    end
  end

  assign pair_sel   = {1'b0, idx[2:1]} + 3'(REG_D10);
  assign digit_pair = regs[pair_sel];
  assign nibble     = idx[0] ? digit_pair[7:4] : digit_pair[3:0];

  // Outputs load once at the start of each digit slot, so a write never tears a lit digit.
  always_ff @(posedge clk_5m_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      div_cnt   <= '0;
      idx       <= 3'd0;
      segment_o <= 8'hFF;
      digit_o   <= 8'hFF;
    end else begin
      if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (div_cnt == '0) begin
        segment_o <= {~regs[REG_DP][idx], ~hex7seg(nibble)};
        digit_o   <= regs[REG_EN][idx] ? ~(8'b1 << idx) : 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_nexys4_display.sv
// Randomised self-checking bench for nexys4_display against a register-level reference model.
`timescale 1ns/1ps
module tb_nexys4_display;

  localparam int REFRESH_DIV = 4;

  logic       clk_5m_i   = 1'b0;
  logic       rst_low_i  = 1'b1;
  logic       spi_sclk_i = 1'b1;
  logic       spi_ss_i   = 1'b1;
  logic       spi_mosi_i = 1'b1;
  logic       spi_miso_o;
  logic [7:0] segment_o;
  logic [7:0] digit_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_regs [6];
  logic [3:0] model_rd_addr;
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  nexys4_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk_5m_i   (clk_5m_i),
    .rst_low_i  (rst_low_i),
    .spi_sclk_i (spi_sclk_i),
    .spi_ss_i   (spi_ss_i),
    .spi_mosi_i (spi_mosi_i),
    .spi_miso_o (spi_miso_o),
    .segment_o  (segment_o),
    .digit_o    (digit_o)
  );

  always #80 clk_5m_i = ~clk_5m_i;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    model_regs    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    model_rd_addr = 4'h0;
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    return (a < 4'd6) ? model_regs[int'(a)] : 8'h00;
  endfunction

  task automatic model_frame(input logic [15:0] w);
    if (w[15:12] == 4'h1 && w[11:8] < 4'd6) model_regs[int'(w[11:8])] = w[7:0];
    else if (w[15:12] == 4'h0) model_rd_addr = w[11:8];
  endtask

  function automatic logic [3:0] model_nibble(input int d);
    logic [7:0] pair;
    pair = model_regs[1 + d / 2];
    return (d % 2 == 1) ? pair[7:4] : pair[3:0];
  endfunction

  // One SPI transfer; each MISO bit is sampled 600 ns after the sclk fall that launched it.
  task automatic apply_stimulus(input logic [31:0] value, input int nbits, output logic [15:0] miso_word);
    miso_word = 16'hFFFF;
    spi_ss_i = 1'b0;
    #800;
    for (int i = 0; i < nbits; i++) begin
      spi_sclk_i = 1'b0;
      #50 spi_mosi_i = value[nbits-1-i];
      #150 spi_sclk_i = 1'b1;
      if (i > 0 && i <= 16) miso_word[16-i] = spi_miso_o;
      #200;
    end
    #200;
    if (nbits <= 16) miso_word[16-nbits] = spi_miso_o;
    #400 spi_ss_i = 1'b1;
    spi_mosi_i = 1'b1;
    #800;
  endtask

  task automatic send_and_check(input string tag, input logic [15:0] w);
    logic [15:0] got;
    logic [15:0] want;
    want = {4'h0, model_rd_addr, model_read(model_rd_addr)};
    apply_stimulus({16'h0, w}, 16, got);
    check_output(tag, {16'h0, got}, {16'h0, want});
    model_frame(w);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 6; a++) send_and_check(tag, {4'h0, 4'(a), 8'h00});
    send_and_check(tag, 16'h0000);
  endtask

  task automatic idle_clocks(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      spi_sclk_i = 1'b0;
      #50 spi_mosi_i = w[i];
      #150 spi_sclk_i = 1'b1;
      #200;
    end
    spi_mosi_i = 1'b1;
    #800;
  endtask

  task automatic check_display(input string tag);
    logic [7:0] seen;
    logic [7:0] inv;
    int idx;
    seen = 8'h00;
    repeat (8 * REFRESH_DIV + 2) @(negedge clk_5m_i);
    repeat (16 * REFRESH_DIV) begin
      @(negedge clk_5m_i);
      inv = ~digit_o;
      check_output({tag, "_anode"}, {31'h0, $onehot0(inv)}, 32'd1);
      if (inv != 8'h00) begin
        idx = 0;
        for (int d = 0; d < 8; d++) if (inv[d]) idx = d;
        seen[idx] = 1'b1;
        check_output({tag, "_seg"}, {24'h0, segment_o},
                     {24'h0, ~model_regs[0][idx], ~font[model_nibble(idx)]});
      end
    end
    for (int d = 0; d < 8; d++) check_output({tag, "_lit"}, {31'h0, seen[d]}, {31'h0, model_regs[5][d]});
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] w;
    int kind;
    int nb;
    model_reset();
    #5 rst_low_i = 1'b0;
    #300;
    check_output("rst_seg", {24'h0, segment_o}, 32'hFF);
    check_output("rst_digit", {24'h0, digit_o}, 32'hFF);
    check_output("rst_miso", {31'h0, spi_miso_o}, 32'd1);
    #100 rst_low_i = 1'b1;
    #800;
    check_output("idle_miso", {31'h0, spi_miso_o}, 32'd1);
    read_all("rst_regs");

    send_and_check("wr_dp", 16'h100C);
    send_and_check("wr_r1", 16'h11AA);
    send_and_check("wr_r2", 16'h12BB);
    send_and_check("wr_r3", 16'h13CC);
    send_and_check("wr_r4", 16'h14DD);
    check_display("scan_abcd");

    send_and_check("rd_req4", 16'h04FF);
    apply_stimulus(32'h0000_0000, 16, m);
    check_output("rd_data4", {16'h0, m}, 32'h04DD);
    model_frame(16'h0000);
    read_all("after_read");

    send_and_check("bad_cmd", 16'hFF77);
    read_all("after_bad");

    idle_clocks(16'h11EE);
    read_all("ss_high");

    apply_stimulus(32'h0000_015F, 12, m);
    read_all("short_frame");
    send_and_check("en_off", 16'h1500);
    check_display("blank");
    send_and_check("en_on", 16'h15FF);

    fork
      apply_stimulus(32'h0000_11EE, 16, m);
      begin
        #2900 rst_low_i = 1'b0;
        #1;
        check_output("midrst_seg", {24'h0, segment_o}, 32'hFF);
        check_output("midrst_digit", {24'h0, digit_o}, 32'hFF);
        check_output("midrst_miso", {31'h0, spi_miso_o}, 32'd1);
        #300 rst_low_i = 1'b1;
      end
    join
    model_reset();
    read_all("after_midrst");
    send_and_check("wr_after_rst", 16'h1133);
    read_all("accept_after_rst");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0: nb = 8;
          1: nb = 12;
          2: nb = 17;
          default: nb = 20;
        endcase
        apply_stimulus($urandom, nb, m);
      end else begin
        w[15:12] = (kind < 6) ? 4'h1 : (kind < 8) ? 4'h0 : 4'($urandom_range(0, 15));
        w[11:8]  = 4'($urandom_range(0, 7));
        w[7:0]   = 8'($urandom);
        send_and_check("rand", w);
      end
    end
    read_all("rand_regs");
    check_display("rand_scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
